// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline write-back (A) always wins, long-latency results (B) queue and drain into idle slots.
// Define WBARB_PERF_EN to add the conflict_cnt and squash_cnt performance counters.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        a_we,
  input  logic [4:0]                  a_waddr,
  input  logic [31:0]                 a_wdata,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [4:0]                  b_waddr,
  input  logic [31:0]                 b_wdata,
  input  logic [4:0]                  raddr1,
  input  logic [4:0]                  raddr2,
  output logic                        pend_hit1,
  output logic                        pend_hit2,
  output logic                        stall_req,
  output logic                        rf_we,
  output logic [4:0]                  rf_waddr,
  output logic [31:0]                 rf_wdata,
`ifdef WBARB_PERF_EN
  output logic [31:0]                 conflict_cnt,
  output logic [31:0]                 squash_cnt,
`endif
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [3:0]    LIMIT    = 4'(STARVE_LIMIT);

  logic [4:0]            addr_q [FIFO_DEPTH];
  logic [31:0]           data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q;
  logic [FIFO_DEPTH-1:0] live_next;
  logic [PW-1:0]         head_q;
  logic [PW-1:0]         tail_q;
  logic [CW-1:0]         count_q;
  logic [3:0]            starve_q;
  logic [3:0]            starve_next;
  logic                  popped_q;

  logic        a_req;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;
  logic        push_killed;
  logic [31:0] kills;
  logic [4:0]  head_addr;
  logic [31:0] head_data;
  logic        head_live;

  assign a_req      = a_we && (a_waddr != 5'd0);
  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign b_ready    = !full && !rst;
  assign push       = b_valid && b_ready;
  assign pop        = !a_req && !empty;
  assign head_addr  = addr_q[head_q];
  assign head_data  = data_q[head_q];
  assign head_live  = live_q[head_q];
  assign fifo_count = count_q;

  // An A write kills every queued entry for the same register, including
  // the one arriving this cycle, since B results are architecturally older.
  assign push_killed = a_req && (b_waddr == a_waddr);

  always_comb begin
    live_next = live_q;
    kills     = '0;
    if (pop) begin
      live_next[head_q] = 1'b0;
    end
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (a_req && live_q[i] && (addr_q[i] == a_waddr)) begin
        live_next[i] = 1'b0;
        kills        = kills + 32'd1;
      end
    end
    if (push) begin
      live_next[tail_q] = !push_killed;
      if (push_killed) begin
        kills = kills + 32'd1;
      end
    end
  end

  always_comb begin
    starve_next = starve_q;
    if (empty || pop) begin
      starve_next = '0;
    end else if (starve_q != 4'hF) begin
      starve_next = starve_q + 4'd1;
    end
  end

  always_comb begin
    pend_hit1 = 1'b0;
    pend_hit2 = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (live_q[i] && (addr_q[i] == raddr1)) begin
        pend_hit1 = 1'b1;
      end
      if (live_q[i] && (addr_q[i] == raddr2)) begin
        pend_hit2 = 1'b1;
      end
    end
    if (rst || (raddr1 == 5'd0)) begin
      pend_hit1 = 1'b0;
    end
    if (rst || (raddr2 == 5'd0)) begin
      pend_hit2 = 1'b0;
    end
  end

  // Payload storage needs no reset: the live bits and count gate every use.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_q[tail_q] <= b_waddr;
      data_q[tail_q] <= b_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      live_q    <= '0;
      starve_q  <= '0;
      popped_q  <= 1'b0;
      stall_req <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      live_q   <= live_next;
      starve_q <= starve_next;
      popped_q <= pop;
      if (push) begin
        tail_q <= tail_q + PW'(1);
      end
      if (pop) begin
        head_q <= head_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      // Set wins over the clear one edge after a pop, so a fresh starvation
      // run is never masked by the tail of the previous one.
      if (starve_next == LIMIT) begin
        stall_req <= 1'b1;
      end else if (popped_q) begin
        stall_req <= 1'b0;
      end

      if (a_req) begin
        rf_we    <= 1'b1;
        rf_waddr <= a_waddr;
        rf_wdata <= a_wdata;
      end else if (!empty) begin
        rf_we    <= head_live && (head_addr != 5'd0);
        rf_waddr <= head_addr;
        rf_wdata <= head_data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

`ifdef WBARB_PERF_EN
  logic [32:0] squash_sum;
  assign squash_sum = {1'b0, squash_cnt} + {1'b0, kills};

  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
      squash_cnt   <= '0;
    end else begin
      if (a_req && !empty && (conflict_cnt != '1)) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
      squash_cnt <= squash_sum[32] ? '1 : squash_sum[31:0];
    end
  end
`else
  logic unused_kills;
  assign unused_kills = ^kills;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector bench for regfile_wb_arbiter at default parameters (FIFO_DEPTH=2, STARVE_LIMIT=4).
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_we;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  fifo_count;

  logic [31:0] shadow [32];

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .pend_hit1(pend_hit1), .pend_hit2(pend_hit2), .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the register file the arbiter feeds.
  initial for (int i = 0; i < 32; i++) shadow[i] = '0;
  always @(posedge clk) if (rf_we) shadow[rf_waddr] <= rf_wdata;

  typedef struct {
    logic        rst;
    logic        a_we;
    logic [4:0]  a_waddr;
    logic [31:0] a_wdata;
    logic        b_valid;
    logic [4:0]  b_waddr;
    logic [31:0] b_wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
    logic        e_rdy;
    logic        e_p1;
    logic        e_p2;
    logic        e_stall;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                       input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                       input logic [4:0] r1, input logic [4:0] r2);
    rst = r; a_we = aw; a_waddr = aa; a_wdata = ad;
    b_valid = bv; b_waddr = ba; b_wdata = bd; raddr1 = r1; raddr2 = r2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);

    //           rst a_we aa  a_wdata      bv ba  b_wdata      r1  r2   we addr data         cnt rdy p1 p2 stall
    vecs.push_back('{1, 0, 0,  32'h0,       0, 0,  32'h0,       0,  0,   0, 0,  32'h0,       0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  32'h0,       0, 0,  32'h0,       0,  0,   0, 0,  32'h0,       0, 1, 0, 0, 0});
    // single B result drains into an idle slot
    vecs.push_back('{0, 0, 0,  32'h0,       1, 5,  32'hDEAD,    5,  0,   0, 0,  32'h0,       1, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,  32'h0,       0, 0,  32'h0,       5,  0,   1, 5,  32'hDEAD,    0, 1, 0, 0, 0});
    // A busy 3 cycles, B waits
    vecs.push_back('{0, 1, 3,  32'h11,      1, 7,  32'h77,      7,  0,   1, 3,  32'h11,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 3,  32'h11,      0, 0,  32'h0,       7,  0,   1, 3,  32'h11,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 3,  32'h11,      0, 0,  32'h0,       7,  0,   1, 3,  32'h11,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 0, 0,  32'h0,       0, 0,  32'h0,       7,  0,   1, 7,  32'h77,      0, 1, 0, 0, 0});
    // WAW: later A write kills queued B entry
    vecs.push_back('{0, 0, 0,  32'h0,       1, 9,  32'hBB,      9,  0,   0, 7,  32'h77,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 9,  32'hAA,      0, 0,  32'h0,       9,  0,   1, 9,  32'hAA,      1, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  32'h0,       0, 0,  32'h0,       9,  0,   0, 9,  32'hBB,      0, 1, 0, 0, 0});
    // starvation: stall after 4 blocked cycles, clears one edge after the pop
    vecs.push_back('{0, 1, 2,  32'h22,      1, 4,  32'h44,      4,  0,   1, 2,  32'h22,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 2,  32'h22,      0, 0,  32'h0,       4,  0,   1, 2,  32'h22,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 2,  32'h22,      0, 0,  32'h0,       4,  0,   1, 2,  32'h22,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 2,  32'h22,      0, 0,  32'h0,       4,  0,   1, 2,  32'h22,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 2,  32'h22,      0, 0,  32'h0,       4,  0,   1, 2,  32'h22,      1, 1, 1, 0, 1});
    vecs.push_back('{0, 0, 0,  32'h0,       0, 0,  32'h0,       4,  0,   1, 4,  32'h44,      0, 1, 0, 0, 1});
    vecs.push_back('{0, 0, 0,  32'h0,       0, 0,  32'h0,       4,  0,   0, 4,  32'h44,      0, 1, 0, 0, 0});
    // FIFO full: third push waits for the first pop, no pass-through
    vecs.push_back('{0, 1, 1,  32'h01,      1, 10, 32'hA0,      10, 11,  1, 1,  32'h01,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 1,  32'h01,      1, 11, 32'hB0,      10, 11,  1, 1,  32'h01,      2, 0, 1, 1, 0});
    vecs.push_back('{0, 1, 1,  32'h01,      1, 12, 32'hC0,      10, 11,  1, 1,  32'h01,      2, 0, 1, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,       1, 12, 32'hC0,      10, 11,  1, 10, 32'hA0,      1, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,       1, 12, 32'hC0,      10, 12,  1, 11, 32'hB0,      1, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 0,  32'h0,       0, 0,  32'h0,       10, 12,  1, 12, 32'hC0,      0, 1, 0, 0, 0});
    // same-cycle push and A write to one register: entry born dead
    vecs.push_back('{0, 1, 6,  32'h66,      1, 6,  32'h60,      6,  0,   1, 6,  32'h66,      1, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  32'h0,       0, 0,  32'h0,       6,  0,   0, 6,  32'h60,      0, 1, 0, 0, 0});
    // A write to $0 leaves the slot to B
    vecs.push_back('{0, 0, 0,  32'h0,       1, 8,  32'h88,      8,  0,   0, 6,  32'h60,      1, 1, 1, 0, 0});
    vecs.push_back('{0, 1, 0,  32'h99,      0, 0,  32'h0,       8,  0,   1, 8,  32'h88,      0, 1, 0, 0, 0});
    // B result for $0: never hits, never writes
    vecs.push_back('{0, 0, 0,  32'h0,       1, 0,  32'h0F,      0,  8,   0, 8,  32'h88,      1, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0,  32'h0,       0, 0,  32'h0,       0,  8,   0, 0,  32'h0F,      0, 1, 0, 0, 0});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].a_we, vecs[i].a_waddr, vecs[i].a_wdata,
            vecs[i].b_valid, vecs[i].b_waddr, vecs[i].b_wdata, vecs[i].r1, vecs[i].r2);
      tick();
      chk($sformatf("vec%0d", i),
          {20'h0, rf_we, rf_waddr, rf_wdata, fifo_count, b_ready, pend_hit1, pend_hit2, stall_req},
          {20'h0, vecs[i].e_we, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_cnt,
           vecs[i].e_rdy, vecs[i].e_p1, vecs[i].e_p2, vecs[i].e_stall});
    end

    // Reset with two entries pending discards them.
    drive(1'b0, 1, 1, 32'h01, 1, 13, 32'hD0, 13, 14);
    tick();
    chk("pre_rst_count1", 64'(fifo_count), 64'd1);
    drive(1'b0, 1, 1, 32'h01, 1, 14, 32'hE0, 13, 14);
    tick();
    chk("pre_rst_full", {62'h0, fifo_count}, 64'd2);
    chk("pre_rst_pend", {62'h0, pend_hit1, pend_hit2}, 64'd3);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 13, 14);
    tick();
    chk("rst_outputs",
        {20'h0, rf_we, rf_waddr, rf_wdata, fifo_count, b_ready, pend_hit1, pend_hit2, stall_req},
        64'h0);
    drive(1'b0, 0, 0, 0, 0, 0, 0, 13, 14);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("post_rst_idle%0d", i), {58'h0, rf_we, fifo_count, pend_hit1, pend_hit2, stall_req}, 64'h0);
    end

    chk("rf9_final",  64'(shadow[9]),  64'hAA);
    chk("rf6_final",  64'(shadow[6]),  64'h66);
    chk("rf12_final", 64'(shadow[12]), 64'hC0);
    chk("rf13_unwritten", 64'(shadow[13]), 64'h0);
    chk("rf14_unwritten", 64'(shadow[14]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
